// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle shift/rotate controller.  A command (operand, operation,
// total amount 0..2^AMT_W-1) is accepted over a valid/ready handshake.
// The amount is split into passes of at most MAX_STEP positions.  Each pass
// runs the 8-bit combinational `shifter` once and feeds its output back into
// the working register.  When the whole amount has been applied, the result
// is offered on a valid/ready output handshake.
//
// Optional feature (macro SHIFT_SEQ_EARLY_TERM_EN):
//   When defined, a SHIFT cycle whose working value can no longer change
//   (zero under a logical/arithmetic-left or logical-right shift, or 0x00/0xFF
//   under an arithmetic right shift) finishes immediately.  Results are
//   unchanged; only latency shrinks.  The default build leaves it undefined.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   command valid
//   in_ready   out  command accepted when in_valid & in_ready (IDLE only)
//   in_data    in   8-bit signed operand
//   in_op      in   3-bit operation (0/7 pass, 1 lsl, 2 asl, 3 lsr, 4 asr,
//                   5 rotl, 6 rotr)
//   in_amt     in   AMT_W-bit total shift amount
//   out_valid  out  result valid (DONE state)
//   out_ready  in   result sink ready
//   out_data   out  8-bit signed result, 0 outside DONE
//   busy       out  high in SHIFT or DONE
// ---------------------------------------------------------------------------

// Combinational 8-bit shifter: one pass of 0..7 positions.
module shifter (
  input  logic [7:0] din,
  input  logic [2:0] sel,
  input  logic [2:0] shift_count,
  output logic [7:0] dout
);

  logic [15:0] rot_left;
  logic [15:0] rot_right;

  // Rotates are built by shifting a doubled copy of the operand, so the
  // bits leaving one end reappear at the other.
  always_comb begin
    rot_left  = {din, din} << shift_count;
    rot_right = {din, din} >> shift_count;
  end

  // Operation select.  Arithmetic left is identical to logical left.
  always_comb begin
    dout = din;
    case (sel)
      3'd1, 3'd2: dout = din << shift_count;
      3'd3:       dout = din >> shift_count;
      3'd4:       dout = 8'($signed(din) >>> shift_count);
      3'd5:       dout = rot_left[15:8];
      3'd6:       dout = rot_right[7:0];
      default:    dout = din;
    endcase
  end

endmodule

module shift_sequencer #(
  parameter int AMT_W    = 5,
  parameter int MAX_STEP = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic [2:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;

  logic [7:0]       work;
  logic [2:0]       op_r;
  logic [AMT_W-1:0] rem;

  logic [2:0]       step;
  logic [AMT_W-1:0] rem_next;
  logic [7:0]       shift_dout;
  logic             early_term;

  // Per-pass count is the smaller of what is left and the largest pass the
  // shifter supports.  Since step never exceeds rem, rem cannot underflow.
  // AMT_W is expected to be at least 3 so rem can hold a full pass.
  always_comb begin
    if (rem < AMT_W'(MAX_STEP)) begin
      step = rem[2:0];
    end else begin
      step = 3'(MAX_STEP);
    end
    rem_next = rem - AMT_W'(step);
  end

  shifter u_shifter (
    .din         (work),
    .sel         (op_r),
    .shift_count (step),
    .dout        (shift_dout)
  );

`ifdef SHIFT_SEQ_EARLY_TERM_EN
  // A working value that is already at the fixed point of its operation
  // will not change with further passes, so the command can finish now.
  always_comb begin
    early_term = 1'b0;
    if ((op_r == 3'd1 || op_r == 3'd2 || op_r == 3'd3) && work == 8'h00) begin
      early_term = 1'b1;
    end else if (op_r == 3'd4 && (work == 8'h00 || work == 8'hFF)) begin
      early_term = 1'b1;
    end
  end
`else
  // Without early termination every command runs all of its passes.
  always_comb begin
    early_term = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs.  A zero amount still spends one SHIFT
  // cycle (step 0, pass-through) because the DONE decision uses rem_next.
  // in_ready is tied to IDLE only, so no command is taken during the output
  // handshake cycle.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    out_data   = 8'h00;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (early_term || rem_next == '0) begin
          next_state = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = work;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: command fields are captured only on the accepting edge; each
  // SHIFT cycle writes back one shifter pass and retires its step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= 8'h00;
      op_r <= 3'd0;
      rem  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= in_data;
            op_r <= in_op;
            rem  <= in_amt;
          end
        end
        SHIFT: begin
          if (early_term) begin
            rem <= '0;
          end else begin
            work <= shift_dout;
            rem  <= rem_next;
          end
        end
        default: begin
          work <= work;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
//
// Self-checking bench for shift_sequencer.  Each accepted command pushes its
// expected result and latency onto a scoreboard; the entry is popped and
// compared when out_valid appears.  Expected values come from a reference
// that applies the total amount in one step.
// ---------------------------------------------------------------------------
module tb_shift_sequencer;

  localparam int AMT_W    = 5;
  localparam int MAX_STEP = 7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic [2:0]       in_op;
  logic [AMT_W-1:0] in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             busy;

  typedef struct {
    logic [7:0] data;
    int         lat;
    string      tag;
  } exp_t;

  exp_t sb[$];

  int check_count = 0;
  int error_count = 0;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  shift_sequencer #(
    .AMT_W    (AMT_W),
    .MAX_STEP (MAX_STEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: one shift by the total amount.
  function automatic logic [7:0] ref_shift(input logic [7:0] d,
                                           input logic [2:0] op,
                                           input int amt);
    logic [15:0] dbl;
    logic [7:0]  res;
    int          r;
    r   = amt % 8;
    res = d;
    case (op)
      3'd1, 3'd2: res = (amt >= 8) ? 8'h00 : 8'(d << amt);
      3'd3:       res = (amt >= 8) ? 8'h00 : 8'(d >> amt);
      3'd4:       res = (amt >= 8) ? {8{d[7]}} : 8'($signed(d) >>> amt);
      3'd5: begin
        dbl = {d, d} << r;
        res = dbl[15:8];
      end
      3'd6: begin
        dbl = {d, d} >> r;
        res = dbl[7:0];
      end
      default: res = d;
    endcase
    return res;
  endfunction

  // Expected cycles from accept edge to out_valid.
  function automatic int ref_latency(input logic [7:0] d, input logic [2:0] op,
                                     input int amt);
`ifdef SHIFT_SEQ_EARLY_TERM_EN
    int         rem;
    int         cyc;
    int         stp;
    logic [7:0] w;
    rem = amt;
    cyc = 0;
    w   = d;
    while (1) begin
      cyc++;
      if (((op == 3'd1 || op == 3'd2 || op == 3'd3) && w == 8'h00) ||
          (op == 3'd4 && (w == 8'h00 || w == 8'hFF))) break;
      stp = (rem < MAX_STEP) ? rem : MAX_STEP;
      w   = ref_shift(w, op, stp);
      rem = rem - stp;
      if (rem == 0) break;
    end
    return cyc;
`else
    return (amt == 0) ? 1 : (amt + MAX_STEP - 1) / MAX_STEP;
`endif
  endfunction

  // Drive one command, wait (bounded) for acceptance, record expectation,
  // then scramble the inputs to show they are only sampled at accept.
  task automatic applyStimulus(input string tag, input logic [7:0] d,
                               input logic [2:0] op, input logic [AMT_W-1:0] amt);
    int waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    in_amt   = amt;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput({tag, "_accept_timeout"}, 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.data = ref_shift(d, op, int'(amt));
    e.lat  = ref_latency(d, op, int'(amt));
    e.tag  = tag;
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_op    = 3'($urandom);
    in_amt   = AMT_W'($urandom);
  endtask

  // Wait (bounded) for out_valid after an accept, check result and latency,
  // and optionally complete the output handshake.
  task automatic waitAndCompare(input bit do_handshake);
    int   lat;
    exp_t e;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!out_valid) checkOutput("busy_while_shift", {31'd0, busy}, 32'd1);
    end while (!out_valid && lat < 40);
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    checkOutput({e.tag, "_data"}, {24'd0, out_data}, {24'd0, e.data});
    checkOutput({e.tag, "_latency"}, lat, e.lat);
    checkOutput({e.tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
    if (do_handshake) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput({e.tag, "_valid_after_hs"}, {31'd0, out_valid}, 32'd0);
      checkOutput({e.tag, "_in_ready_after_hs"}, {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    logic [7:0] held;
    bit         ghost;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_op     = 3'd0;
    in_amt    = '0;
    out_ready = 1'b1;

    // Reset state.
    #12;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_data", {24'd0, out_data}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors.
    applyStimulus("amt0", 8'h9D, 3'd1, 5'd0);
    waitAndCompare(1'b1);
    applyStimulus("rotl10", 8'h9D, 3'd5, 5'd10);
    waitAndCompare(1'b1);
    applyStimulus("asr12", 8'h9D, 3'd4, 5'd12);
    waitAndCompare(1'b1);
    applyStimulus("lsr9", 8'h9D, 3'd3, 5'd9);
    waitAndCompare(1'b1);
    applyStimulus("lsr31", 8'h9D, 3'd3, 5'd31);
    waitAndCompare(1'b1);
    applyStimulus("pass7", 8'h9D, 3'd7, 5'd20);
    waitAndCompare(1'b1);
    applyStimulus("asl7", 8'h5B, 3'd2, 5'd7);
    waitAndCompare(1'b1);
    applyStimulus("asr_pos", 8'h6C, 3'd4, 5'd3);
    waitAndCompare(1'b1);

    // Backpressure: result held, stall-time in_valid pulses ignored.
    out_ready = 1'b0;
    applyStimulus("bp_rotr2", 8'h9D, 3'd6, 5'd2);
    waitAndCompare(1'b0);
    held = out_data;
    checkOutput("bp_expected_value", {24'd0, held}, 32'h67);
    repeat (4) begin
      in_valid = 1'b1;
      in_data  = 8'h11;
      in_op    = 3'd1;
      in_amt   = 5'd1;
      checkOutput("bp_valid_held", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_data_held", {24'd0, out_data}, 32'h67);
      checkOutput("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_valid_after_hs", {31'd0, out_valid}, 32'd0);
    checkOutput("bp_busy_after_hs", {31'd0, busy}, 32'd0);
    checkOutput("bp_in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;

    // Reset in the 3rd SHIFT cycle of a long command.
    applyStimulus("rst_mid", 8'h9D, 3'd1, 5'd31);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_out_data", {24'd0, out_data}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ghost = 1'b0;
    repeat (8) begin
      @(negedge clk);
      ghost = ghost | out_valid;
    end
    checkOutput("midrst_no_ghost_valid", {31'd0, ghost}, 32'd0);
    applyStimulus("after_rst", 8'hA5, 3'd5, 5'd13);
    waitAndCompare(1'b1);

    // Random commands.
    for (int i = 0; i < 16; i++) begin
      applyStimulus($sformatf("rand%0d", i), 8'($urandom), 3'($urandom_range(0, 7)),
                    AMT_W'($urandom_range(0, 31)));
      waitAndCompare(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
